led_pattern_counter: RTL
========================

# led_pattern_counter

Parametrised LED pattern generator: a free-running prescaler derives a step tick from the system clock, and on every tick a WIDTH-bit LED register advances according to a runtime-selectable mode. Four modes are supported: binary up, binary down, bounce sweep and Gray count. The block sits directly on the board LED pins and replaces the fixed 8-bit half-second up-counter.

## Interface
- CLK_FREQ, 25_000_000: system clock frequency in Hz.
- STEP_HZ, 2: LED steps per second. DIV = CLK_FREQ / STEP_HZ (integer division). Elaboration error if DIV < 1.
- WIDTH, 8: LED count. Must be >= 1.

- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  high: prescaler runs. Low: prescaler and pattern frozen.
- mode  input  2  00 up, 01 down, 10 bounce, 11 Gray.
- leds  output  WIDTH  LED pattern, registered.
- tick  output  1  one-cycle pulse, high in the first cycle a new leds value is visible.

## Operation
- Prescaler `pcnt` counts 0..DIV-1 while enable=1. A step fires at the edge where pcnt==DIV-1 and enable=1; pcnt wraps to 0 on that edge.
- DIV==1: a step fires on every enabled cycle.
- Registered `mode_q` tracks the active mode.
- When mode != mode_q (mode-change event), on that edge:
  - mode_q <= mode;
  - pcnt <= 0;
  - leds loads the new mode's initial value;
  - bin <= 0;
  - dir <= left;
  - tick <= 0.
  - A mode-change event overrides a coincident step and is honoured even when enable=0.
- Initial values per mode: up 0; down all-ones; bounce 1 (LSB lit); Gray 0.
- Step behaviour:
  - Up: leds+1, wrapping from all-ones to 0.
  - Down: leds-1, wrapping from 0 to all-ones.
  - Bounce, one-hot:
    - dir=left: shift left. When the result has the MSB set, dir <= right.
    - dir=right: shift right. When the result equals 1, dir <= left.
    - WIDTH=1: leds stays 1.
    - Sequence for WIDTH=4: 1,2,4,8,4,2,1,2,…
  - Gray:
    - Internal WIDTH-bit binary counter bin <= bin+1 (wrapping).
    - leds <= (bin+1) ^ ((bin+1) >> 1).
- enable=0 freezes pcnt, leds, bin and dir. It does not clear them. Re-enable resumes from the frozen pcnt.

## Timing
- Reset values: leds=0, tick=0, pcnt=0, bin=0, dir=left, mode_q=00. Reset has priority over all other events.
- If mode != 00 in the first cycle after reset, the mode-change rule applies on that edge.
- Latency: with enable held high from reset release and no mode change, the first new leds value and tick appear DIV cycles after the first non-reset edge.
- Steps then recur every DIV enabled cycles.
- tick is high for exactly one cycle per step. It is never high on a mode-change or reset cycle.
- Reset asserted mid-count: the next edge restores all reset values. The partial prescale count is discarded.

## Configuration
- Macro LED_PATTERN_STEP_EN.
- Defined: adds input `step_req` (1 bit). When enable=0 and step_req=1, that edge performs one pattern step and pulses tick.
  - pcnt is unchanged by a manual step.
  - A manual step is ignored when enable=1, and ignored on a mode-change edge.
- Undefined: the port is absent and there is no manual stepping. All other behaviour is identical.

## Structure
- Package `led_pattern_pkg`:
  - 2-bit mode constants MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_GRAY;
  - dir encoding DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module `tick_gen` (parameter DIV):
  - inputs clk, rst, enable, clear;
  - output step;
  - contains pcnt, sized $clog2(DIV) bits with a minimum of 1.
- Top level holds mode_q, leds, bin, dir and the tick register.

## Test plan
Unless noted, CLK_FREQ=8, STEP_HZ=2 (DIV=4), WIDTH=4.
- Up mode: reset, enable=1, mode=00 → leds steps 1,2,3 at cycles 4,8,12. tick pulses in those cycles. leds wraps 15→0 at cycle 64.
- Down mode: mode=01 from reset → edge 1 loads 15; leds 14 at cycle 5; leds wraps 0→15 after 16 steps.
- Bounce mode: mode=10 → leds 1,2,4,8,4,2,1,2 on successive steps. Repeat with WIDTH=1 → leds constant 1, tick still pulses.
- Gray mode: mode=11 → leds 1,3,2,6,7,5,4,12 on successive steps.
- Freeze and mode change:
  - Drop enable at pcnt=2 for 10 cycles, then raise it → next step 2 enabled cycles later, with no tick while frozen.
  - Switch mode 00→01 mid-count → leds=15 on the next edge, no tick, next step DIV cycles later.
- Reset and manual step:
  - Assert rst with leds=5 → leds=0, tick=0 the next edge.
  - With LED_PATTERN_STEP_EN defined: enable=0, one-cycle step_req in up mode → leds+1 with a tick. step_req with enable=1 → no extra step.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator: mode encodings and bounce direction.
package led_pattern_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_GRAY   = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_counter_tick_gen.sv
// Free-running prescaler: asserts step in the enabled cycle where pcnt reaches DIV-1.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  assign step = enable & (pcnt == LAST);

  // clear (mode change) wins over counting so the next step is a full DIV away
  always_ff @(posedge clk) begin
    if (rst || clear)  pcnt <= '0;
    else if (step)     pcnt <= '0;
    else if (enable)   pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/led_pattern_counter.sv
// LED pattern generator: up / down / bounce / Gray, advanced on each prescaler step.
// Optional LED_PATTERN_STEP_EN adds a step_req input for manual stepping while disabled.
module led_pattern_counter
  import led_pattern_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int STEP_HZ  = 2,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
`ifdef LED_PATTERN_STEP_EN
  input  logic             step_req,
`endif
  output logic [WIDTH-1:0] leds,
  output logic             tick
);

  localparam int DIV = CLK_FREQ / STEP_HZ;

  if (DIV < 1) begin : g_bad_div
    $error("led_pattern_counter: CLK_FREQ / STEP_HZ must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("led_pattern_counter: WIDTH must be >= 1");
  end

  logic [1:0]       mode_q;
  logic [WIDTH-1:0] bin;
  logic             dir;
  logic             mode_chg, auto_step, man_step, do_step;
  logic [WIDTH-1:0] nxt_leds, nxt_bin, bin_inc;
  logic             nxt_dir;

  assign mode_chg = (mode != mode_q);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (mode_chg),
    .step   (auto_step)
  );

`ifdef LED_PATTERN_STEP_EN
  assign man_step = ~enable & step_req;
`else
  assign man_step = 1'b0;
`endif

  // a mode change swallows any coincident automatic or manual step
  assign do_step = ~mode_chg & (auto_step | man_step);

  function automatic logic [WIDTH-1:0] init_leds(input logic [1:0] m);
    case (m)
      MODE_DOWN:   return '1;
      MODE_BOUNCE: return WIDTH'(1);
      default:     return '0;
    endcase
  endfunction

  always_comb begin
    nxt_leds = leds;
    nxt_bin  = bin;
    nxt_dir  = dir;
    bin_inc  = bin + 1'b1;
    case (mode_q)
      MODE_UP:   nxt_leds = leds + 1'b1;
      MODE_DOWN: nxt_leds = leds - 1'b1;
      MODE_BOUNCE: begin
        if (WIDTH == 1) begin
          nxt_leds = WIDTH'(1);
        end else if (dir == DIR_LEFT) begin
          nxt_leds = leds << 1;
          if (nxt_leds[WIDTH-1]) nxt_dir = DIR_RIGHT;
        end else begin
          nxt_leds = leds >> 1;
          if (nxt_leds == WIDTH'(1)) nxt_dir = DIR_LEFT;
        end
      end
      MODE_GRAY: begin
        nxt_bin  = bin_inc;
        nxt_leds = bin_inc ^ (bin_inc >> 1);
      end
      default: nxt_leds = leds;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_UP;
      leds   <= '0;
      bin    <= '0;
      dir    <= DIR_LEFT;
      tick   <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= mode;
      leds   <= init_leds(mode);
      bin    <= '0;
      dir    <= DIR_LEFT;
      tick   <= 1'b0;
    end else if (do_step) begin
      leds   <= nxt_leds;
      bin    <= nxt_bin;
      dir    <= nxt_dir;
      tick   <= 1'b1;
    end else begin
      tick   <= 1'b0;
    end
  end

endmodule
